// File: rtl/alu_pkg.sv
// Shared definitions for the datapath ALU: widths, opcode map and shifter modes.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int SH_W   = $clog2(DATA_W);

  localparam logic [5:0] OP_PASS_A = 6'h00;
  localparam logic [5:0] OP_PASS_B = 6'h01;
  localparam logic [5:0] OP_ADD    = 6'h10;
  localparam logic [5:0] OP_ADC    = 6'h11;
  localparam logic [5:0] OP_SUB    = 6'h12;
  localparam logic [5:0] OP_SBC    = 6'h13;
  localparam logic [5:0] OP_INC    = 6'h14;
  localparam logic [5:0] OP_DEC    = 6'h15;
  localparam logic [5:0] OP_NEG    = 6'h16;
  localparam logic [5:0] OP_AND    = 6'h20;
  localparam logic [5:0] OP_OR     = 6'h21;
  localparam logic [5:0] OP_XOR    = 6'h22;
  localparam logic [5:0] OP_NOR    = 6'h23;
  localparam logic [5:0] OP_NAND   = 6'h24;
  localparam logic [5:0] OP_XNOR   = 6'h25;
  localparam logic [5:0] OP_NOT    = 6'h26;
  localparam logic [5:0] OP_SLL    = 6'h30;
  localparam logic [5:0] OP_SRL    = 6'h31;
  localparam logic [5:0] OP_SRA    = 6'h32;
  localparam logic [5:0] OP_ROL    = 6'h33;
  localparam logic [5:0] OP_ROR    = 6'h34;
  localparam logic [5:0] OP_SLT    = 6'h38;
  localparam logic [5:0] OP_SLTU   = 6'h39;

  // Encoded to match the low three bits of the shift opcodes.
  typedef enum logic [2:0] {
    SH_SLL = 3'd0,
    SH_SRL = 3'd1,
    SH_SRA = 3'd2,
    SH_ROL = 3'd3,
    SH_ROR = 3'd4
  } shift_op_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter/rotator; also returns the last bit moved out.
module alu_shifter
  import alu_pkg::*;
#(
  parameter  int WIDTH = DATA_W,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    sh,
  input  shift_op_t        op,
  output logic [WIDTH-1:0] res,
  output logic             bit_out
);

  logic [WIDTH:0]   sll_w;
  logic [WIDTH:0]   srl_w;
  logic [WIDTH:0]   sra_w;
  logic [SW:0]      inv_sh;
  logic [WIDTH-1:0] rol_w;
  logic [WIDTH-1:0] ror_w;

  // A guard bit next to the operand catches the last bit out; it stays 0 when sh=0.
  assign sll_w  = {1'b0, a} << sh;
  assign srl_w  = {a, 1'b0} >> sh;
  assign sra_w  = $signed({a, 1'b0}) >>> sh;
  assign inv_sh = (SW+1)'(WIDTH) - {1'b0, sh};
  assign rol_w  = (a << sh) | (a >> inv_sh);
  assign ror_w  = (a >> sh) | (a << inv_sh);

  always_comb begin
    res     = a;
    bit_out = 1'b0;
    case (op)
      SH_SLL: begin res = sll_w[WIDTH-1:0]; bit_out = sll_w[WIDTH]; end
      SH_SRL: begin res = srl_w[WIDTH:1];   bit_out = srl_w[0];     end
      SH_SRA: begin res = sra_w[WIDTH:1];   bit_out = sra_w[0];     end
      SH_ROL: begin res = rol_w;            bit_out = sll_w[WIDTH]; end
      SH_ROR: begin res = ror_w;            bit_out = srl_w[0];     end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Registered 32-bit ALU: one op per cycle, result/carry registered, Z/N from the registered result.
module alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = DATA_W,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       opCode,
  input  logic             c,
  output logic [WIDTH-1:0] ans1,
  output logic             ans2,
  output logic             Z,
  output logic             N
);

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_ci;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sh_res;
  logic             sh_out;
  logic [WIDTH-1:0] res_d;
  logic             co_d;

  // All arithmetic ops share one adder; operands are conditioned per opcode.
  always_comb begin
    add_x  = a;
    add_y  = b;
    add_ci = 1'b0;
    case (opCode)
      OP_ADC: add_ci = c;
      OP_SUB: begin add_y = ~b; add_ci = 1'b1; end
      OP_SBC: begin add_y = ~b; add_ci = c;    end
      OP_INC: begin add_y = '0; add_ci = 1'b1; end
      OP_DEC: add_y = '1;
      OP_NEG: begin add_x = ~a; add_y = '0; add_ci = 1'b1; end
      default: ;
    endcase
  end

  assign sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .a       (a),
    .sh      (b[SW-1:0]),
    .op      (shift_op_t'(opCode[2:0])),
    .res     (sh_res),
    .bit_out (sh_out)
  );

  always_comb begin
    res_d = '0;
    co_d  = 1'b0;
    case (opCode)
      OP_PASS_A: res_d = a;
      OP_PASS_B: res_d = b;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC,
      OP_INC, OP_DEC, OP_NEG: {co_d, res_d} = sum;
      OP_AND:  res_d = a & b;
      OP_OR:   res_d = a | b;
      OP_XOR:  res_d = a ^ b;
      OP_NOR:  res_d = ~(a | b);
      OP_NAND: res_d = ~(a & b);
      OP_XNOR: res_d = ~(a ^ b);
      OP_NOT:  res_d = ~a;
      OP_SLL, OP_SRL, OP_SRA,
      OP_ROL, OP_ROR: begin res_d = sh_res; co_d = sh_out; end
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, a < b};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ans1 <= '0;
      ans2 <= 1'b0;
    end else begin
      ans1 <= res_d;
      ans2 <= co_d;
    end
  end

  // Flags follow the registered result, so reset naturally yields Z=1, N=0.
  assign Z = (ans1 == '0);
  assign N = ans1[WIDTH-1];

endmodule

// File: tb/tb_alu.sv
// Directed plus randomized scoreboard bench for the registered ALU.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic [5:0]  opCode;
  logic        c;
  logic [31:0] ans1;
  logic        ans2, Z, N;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       tag;
    logic [31:0] r;
    logic        co;
  } exp_t;

  exp_t q[$];

  alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .opCode (opCode),
    .c      (c),
    .ans1   (ans1),
    .ans2   (ans2),
    .Z      (Z),
    .N      (N)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    assert (act === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp({e.tag, " ans1"}, ans1, e.r);
      cmp({e.tag, " ans2"}, {31'b0, ans2}, {31'b0, e.co});
      cmp({e.tag, " Z"},    {31'b0, Z},    {31'b0, (e.r == 32'h0)});
      cmp({e.tag, " N"},    {31'b0, N},    {31'b0, e.r[31]});
    end
  endtask

  task automatic step(input logic [5:0] op, input logic [31:0] aa, input logic [31:0] bb,
                      input logic cc, input logic [31:0] er, input logic ec, input string tag);
    exp_t e;
    @(negedge clk);
    check_out();
    opCode = op; a = aa; b = bb; c = cc;
    e.tag = tag; e.r = er; e.co = ec;
    q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    cmp({tag, " ans1"}, ans1, 32'h0);
    cmp({tag, " ans2"}, {31'b0, ans2}, 32'h0);
    cmp({tag, " Z"},    {31'b0, Z},    32'h1);
    cmp({tag, " N"},    {31'b0, N},    32'h0);
  endtask

  // Reference model written bit-serially / by subtraction, independent of the RTL structure.
  function automatic void model(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                                input logic ci, output logic [31:0] r, output logic co);
    logic [32:0] t;
    int sh;
    r = 32'h0; co = 1'b0; sh = int'(y[4:0]);
    case (op)
      6'h00: r = x;
      6'h01: r = y;
      6'h10: begin t = {1'b0, x} + {1'b0, y}; r = t[31:0]; co = t[32]; end
      6'h11: begin t = {1'b0, x} + {1'b0, y} + {32'b0, ci}; r = t[31:0]; co = t[32]; end
      6'h12: begin t = {1'b0, x} - {1'b0, y}; r = t[31:0]; co = ~t[32]; end
      6'h13: begin t = {1'b0, x} - {1'b0, y} - {32'b0, ~ci}; r = t[31:0]; co = ~t[32]; end
      6'h14: begin t = {1'b0, x} + 33'd1; r = t[31:0]; co = t[32]; end
      6'h15: begin t = {1'b0, x} - 33'd1; r = t[31:0]; co = ~t[32]; end
      6'h16: begin t = 33'd0 - {1'b0, x}; r = t[31:0]; co = (x == 32'h0); end
      6'h20: r = x & y;
      6'h21: r = x | y;
      6'h22: r = x ^ y;
      6'h23: r = ~(x | y);
      6'h24: r = ~(x & y);
      6'h25: r = ~(x ^ y);
      6'h26: r = ~x;
      6'h30: begin r = x; for (int i = 0; i < sh; i++) begin co = r[31]; r = {r[30:0], 1'b0}; end end
      6'h31: begin r = x; for (int i = 0; i < sh; i++) begin co = r[0]; r = {1'b0, r[31:1]}; end end
      6'h32: begin r = x; for (int i = 0; i < sh; i++) begin co = r[0]; r = {r[31], r[31:1]}; end end
      6'h33: begin r = x; for (int i = 0; i < sh; i++) begin co = r[31]; r = {r[30:0], r[31]}; end end
      6'h34: begin r = x; for (int i = 0; i < sh; i++) begin co = r[0]; r = {r[0], r[31:1]}; end end
      6'h38: r = (x[31] != y[31]) ? {31'b0, x[31]} : {31'b0, (x < y)};
      6'h39: r = {31'b0, (x < y)};
      default: ;
    endcase
  endfunction

  logic [5:0] ops [27] = '{6'h00, 6'h01, 6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16,
                          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                          6'h30, 6'h31, 6'h32, 6'h33, 6'h34, 6'h38, 6'h39,
                          6'h3F, 6'h02, 6'h17, 6'h35};

  initial begin
    exp_t        e;
    logic [5:0]  rop;
    logic [31:0] ra, rb, er;
    logic        rc, ec;

    rst_n = 1'b1; a = '0; b = '0; opCode = '0; c = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset("reset");
    @(negedge clk) rst_n = 1'b1;

    // Directed, back-to-back: each result must land exactly one edge later.
    step(6'h10, 32'h14,       32'h09,       1'b0, 32'h1D,       1'b0, "add");
    step(6'h11, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        1'b1, "adc_wrap");
    step(6'h12, 32'h5,        32'h7,        1'b0, 32'hFFFFFFFE, 1'b0, "sub_borrow");
    step(6'h12, 32'h7,        32'h7,        1'b1, 32'h0,        1'b1, "sub_eq");
    step(6'h20, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'h00F000F0, 1'b0, "and");
    step(6'h26, 32'h0,        32'h1234,     1'b0, 32'hFFFFFFFF, 1'b0, "not");
    step(6'h3F, 32'hDEADBEEF, 32'h1,        1'b1, 32'h0,        1'b0, "undef");
    step(6'h30, 32'h80000001, 32'h1,        1'b0, 32'h2,        1'b1, "sll");
    step(6'h32, 32'h80000000, 32'd31,       1'b0, 32'hFFFFFFFF, 1'b0, "sra31");
    step(6'h34, 32'h1,        32'h1,        1'b0, 32'h80000000, 1'b1, "ror");
    step(6'h30, 32'h12345678, 32'h20,       1'b0, 32'h12345678, 1'b0, "sll_sh0");
    step(6'h33, 32'h80000000, 32'h1,        1'b0, 32'h1,        1'b1, "rol");
    step(6'h31, 32'h3,        32'h1,        1'b0, 32'h1,        1'b1, "srl");
    step(6'h38, 32'hFFFFFFFF, 32'h1,        1'b0, 32'h1,        1'b0, "slt");
    step(6'h39, 32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        1'b0, "sltu");
    step(6'h10, 32'h1,        32'h1,        1'b1, 32'h2,        1'b0, "add_ignores_c");
    step(6'h14, 32'hFFFFFFFF, 32'h0,        1'b0, 32'h0,        1'b1, "inc_wrap");
    step(6'h15, 32'h0,        32'h0,        1'b0, 32'hFFFFFFFF, 1'b0, "dec_zero");
    step(6'h16, 32'h1,        32'h0,        1'b0, 32'hFFFFFFFF, 1'b0, "neg_one");
    step(6'h16, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, "neg_zero");
    step(6'h13, 32'h5,        32'h3,        1'b0, 32'h1,        1'b1, "sbc");

    // Asynchronous reset while an ADD is waiting for its edge.
    step(6'h10, 32'h100,      32'h23,       1'b0, 32'h123,      1'b0, "add_pending");
    #2 rst_n = 1'b0;
    #1 check_reset("reset_async");
    q.delete();
    @(posedge clk) #1 check_reset("reset_held");
    @(negedge clk) rst_n = 1'b1;
    e.tag = "add_after_reset"; e.r = 32'h123; e.co = 1'b0;
    q.push_back(e);

    for (int i = 0; i < 60; i++) begin
      rop = ops[$urandom_range(0, 26)];
      ra  = $urandom;
      rb  = (i % 4 == 0) ? ra : $urandom;
      rc  = 1'($urandom_range(0, 1));
      model(rop, ra, rb, rc, er, ec);
      step(rop, ra, rb, rc, er, ec, $sformatf("rand%0d_op%h", i, rop));
    end

    @(negedge clk);
    check_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
